// File: rtl/fluid_mem_pkg.sv
// Shared types and memory geometry for the s2 stream reader.
// Word-addressed dual-port RAM: 24576 x 32-bit words.
package fluid_mem_pkg;

  localparam int MEM_ADDR_W = 15;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_WORDS  = 24576;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

endpackage

// File: rtl/stream_sync_fifo.sv
// Small synchronous FIFO with occupancy count (power-of-2 depth).
// Ports: push/wdata in, pop/rdata/empty/count out; async active-low reset.
module stream_sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop & ~empty;
  // A pop frees a slot in the same cycle, so push into full is fine then.
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_d  = wr_q + AW'(do_push);
    rd_d  = rd_q + AW'(do_pop);
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata;
  end

  assign rdata = mem_q[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/onchip_mem_stream_reader.sv
// Avalon-MM read master on RAM port s2, streaming words out valid/ready.
// Ports: cmd_* command in, mem_* s2 master, out_* stream, busy/done/err status.
module onchip_mem_stream_reader
  import fluid_mem_pkg::*;
#(
  parameter int ADDR_W     = MEM_ADDR_W,
  parameter int DATA_W     = MEM_DATA_W,
  parameter int MEM_WORDS  = fluid_mem_pkg::MEM_WORDS,
  parameter int LEN_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_clken,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = ADDR_W + LEN_W + 1;
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(FIFO_DEPTH);
  localparam logic [SW-1:0] WORDS_C = SW'(MEM_WORDS);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              infl_q, infl_d;
  logic              infl_last_q, infl_last_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [CW-1:0]     fifo_cnt;
  logic              fifo_empty;
  logic [DATA_W:0]   fifo_rdata;
  logic [CW:0]       used;
  logic [SW-1:0]     end_sum;
  logic              accept;
  logic              issue;
  logic              pop;
  logic              final_issue;

  assign accept  = cmd_valid & cmd_ready;
  assign end_sum = {{(LEN_W+1){1'b0}}, cmd_addr}
                 + {{(ADDR_W+1){1'b0}}, cmd_len};

  // Credit: buffered words plus the read still in flight must fit.
  assign used  = {1'b0, fifo_cnt} + {{CW{1'b0}}, infl_q};
  assign issue = (state_q == ISSUE) && (used < DEPTH_C);
  assign final_issue = issue && (rem_q == LEN_W'(1));
  assign pop   = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    infl_d      = issue;
    infl_last_d = final_issue;
    done_d      = 1'b0;
    err_d       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (end_sum > WORDS_C) begin
            err_d = 1'b1;
          end else if (cmd_len == '0) begin
            done_d = 1'b1;
          end else begin
            addr_d  = cmd_addr;
            rem_d   = cmd_len;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (issue) begin
          rem_d = rem_q - LEN_W'(1);
          if (final_issue) begin
            state_d = DRAIN;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      DRAIN: begin
        if (pop && fifo_rdata[DATA_W]) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Read data lands one cycle after issue; credit guarantees room.
  stream_sync_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset_n),
    .push  (infl_q),
    .wdata ({infl_last_q, mem_readdata}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  assign cmd_ready      = reset_n & (state_q == IDLE);
  assign busy           = (state_q != IDLE);
  assign done           = done_q;
  assign err            = err_q;

  assign mem_address    = addr_q;
  assign mem_chipselect = issue;
  assign mem_clken      = 1'b1;
  assign mem_write      = 1'b0;
  assign mem_byteenable = 4'hF;
  assign mem_writedata  = '0;

  assign out_valid      = ~fifo_empty;
  assign out_data       = fifo_rdata[DATA_W-1:0];
  assign out_last       = ~fifo_empty & fifo_rdata[DATA_W];

endmodule
